// File: rtl/ram_pkg.sv
// rtl/ram_pkg.sv - shared size encodings and FSM state type for ram_param
package ram_pkg;

  // Access size: number of bytes is 2**size
  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } size_e;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_e;

endpackage

// File: rtl/ram_lane_align.sv
// rtl/ram_lane_align.sv - byte enables, alignment check and load extraction/extension
//
// Purely combinational.
//   off       : byte offset within the word
//   size      : access size (ram_pkg::size_e encoding)
//   uns       : 1 = zero-extend loads, 0 = sign-extend
//   wdata     : right-aligned store data
//   rword     : full memory word at the addressed index
//   be        : byte enables for a store (all zero when the access is bad)
//   wlane     : store data shifted into its byte lanes
//   bad       : access is misaligned or wider than the word
//   load_data : addressed bytes shifted to bit 0 and extended to DATA_W
module ram_lane_align
  import ram_pkg::*;
#(
  parameter int DATA_W = 64,
  localparam int NB    = DATA_W / 8,
  localparam int OFF_W = $clog2(NB)
) (
  input  logic [OFF_W-1:0]  off,
  input  logic [1:0]        size,
  input  logic              uns,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] rword,
  output logic [NB-1:0]     be,
  output logic [DATA_W-1:0] wlane,
  output logic              bad,
  output logic [DATA_W-1:0] load_data
);

  int                nbytes;
  logic [DATA_W-1:0] keep;
  logic [DATA_W-1:0] msb;
  logic [DATA_W-1:0] shifted;
  logic              sign;

  always_comb begin
    nbytes = 1;
    case (size_e'(size))
      SZ_B: nbytes = 1;
      SZ_H: nbytes = 2;
      SZ_W: nbytes = 4;
      SZ_D: nbytes = 8;
    endcase

    // Illegal when wider than the word; misaligned when offset is not a multiple of the size
    bad = (nbytes > NB) || ((int'(off) & (nbytes - 1)) != 0);

    be   = '0;
    keep = '0;
    for (int b = 0; b < NB; b++) begin
      if (!bad && (b >= int'(off)) && (b < int'(off) + nbytes))
        be[b] = 1'b1;
      if (b < nbytes)
        keep[b*8 +: 8] = 8'hFF;
    end

    wlane   = wdata << {off, 3'b000};
    shifted = rword >> {off, 3'b000};

    // Top bit of the kept field is the sign bit; a full-width access has nothing to extend
    msb       = keep & ~(keep >> 1);
    sign      = |(shifted & msb);
    load_data = (shifted & keep) | ((sign && !uns) ? ~keep : '0);
  end

endmodule

// File: rtl/ram_param.sv
// rtl/ram_param.sv - byte-addressable single-port RAM with sized, extended accesses
//
// Optional macro RAM_INIT_PATTERN_EN: preloads mem[0] = 5, mem[i] = i + 3.
//   clk    : rising-edge clock
//   rst    : synchronous active-high reset (memory contents untouched)
//   req    : access request, accepted when ready
//   we     : 1 = store, 0 = load
//   addr   : byte address
//   size   : 0 byte, 1 half, 2 word, 3 double
//   uns    : zero-extend (1) or sign-extend (0) loads
//   wdata  : right-aligned store data
//   ready  : high in IDLE only, low during reset
//   rvalid : one-cycle response strobe
//   rdata  : extended load data, zero otherwise
//   err    : response is misaligned/illegal (qualified by rvalid)
module ram_param
  import ram_pkg::*;
#(
  parameter int DATA_W  = 64,
  parameter int DEPTH   = 32,
  localparam int NB     = DATA_W / 8,
  localparam int OFF_W  = $clog2(NB),
  localparam int IDX_W  = $clog2(DEPTH),
  localparam int ADDR_W = IDX_W + OFF_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [1:0]        size,
  input  logic              uns,
  input  logic [DATA_W-1:0] wdata,
  output logic              ready,
  output logic              rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              err
);

  logic [DATA_W-1:0] mem [DEPTH];

`ifdef RAM_INIT_PATTERN_EN
  initial begin
    mem[0] = DATA_W'(5);
    for (int i = 1; i < DEPTH; i++)
      mem[i] = DATA_W'(i + 3);
  end
`else
  // Contents start undefined until written.
`endif

  state_e            state;
  logic [IDX_W-1:0]  idx;
  logic [OFF_W-1:0]  off;
  logic [NB-1:0]     be;
  logic [DATA_W-1:0] wlane;
  logic [DATA_W-1:0] load_data;
  logic              bad;
  logic              accept;

  assign idx    = addr[ADDR_W-1:OFF_W];
  assign off    = addr[OFF_W-1:0];
  assign ready  = (state == IDLE) && !rst;
  assign accept = req && ready;

  ram_lane_align #(.DATA_W(DATA_W)) u_align (
    .off       (off),
    .size      (size),
    .uns       (uns),
    .wdata     (wdata),
    .rword     (mem[idx]),
    .be        (be),
    .wlane     (wlane),
    .bad       (bad),
    .load_data (load_data)
  );

  // Store commits on the accepting edge so a following load sees it
  always_ff @(posedge clk) begin
    if (accept && we) begin
      for (int b = 0; b < NB; b++)
        if (be[b])
          mem[idx][b*8 +: 8] <= wlane[b*8 +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      rvalid <= 1'b0;
      err    <= 1'b0;
      rdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            state  <= RESP;
            rvalid <= 1'b1;
            err    <= bad;
            rdata  <= (!bad && !we) ? load_data : '0;
          end else begin
            rvalid <= 1'b0;
            err    <= 1'b0;
            rdata  <= '0;
          end
        end
        RESP: begin
          state  <= IDLE;
          rvalid <= 1'b0;
          err    <= 1'b0;
          rdata  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_param.sv
// tb/tb_ram_param.sv - randomized self-checking bench for ram_param against a byte-array model
module tb_ram_param;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        we;
  logic [7:0]  addr;
  logic [1:0]  size;
  logic        uns;
  logic [63:0] wdata;
  logic        ready;
  logic        rvalid;
  logic [63:0] rdata;
  logic        err;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] model_mem [256];

  always #5 clk = ~clk;

  ram_param dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .we     (we),
    .addr   (addr),
    .size   (size),
    .uns    (uns),
    .wdata  (wdata),
    .ready  (ready),
    .rvalid (rvalid),
    .rdata  (rdata),
    .err    (err)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model_load(input int a, input int sz, input bit u);
    int          nb;
    logic [63:0] v;
    nb = 1 << sz;
    v  = '0;
    for (int i = 0; i < nb; i++)
      v = v | (64'(model_mem[a + i]) << (8 * i));
    if (!u && nb < 8 && v[8*nb-1])
      v = v | (~64'd0 << (8 * nb));
    return v;
  endfunction

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (!ready && n < 5) begin
      @(negedge clk);
      n++;
    end
    if (!ready) check({tag, "_ready_timeout"}, 64'(ready), 64'd1);
  endtask

  // One complete access: drive in IDLE, check the response cycle against the model
  task automatic access(input bit w, input logic [7:0] a, input logic [1:0] sz, input bit u,
                        input logic [63:0] wd, input string tag);
    int          nb;
    bit          mis;
    logic [63:0] exp_data;
    nb  = 1 << sz;
    mis = (int'(a) % nb) != 0;
    exp_data = '0;
    if (!mis && !w) exp_data = model_load(int'(a), int'(sz), u);
    if (!mis && w)
      for (int i = 0; i < nb; i++) model_mem[int'(a) + i] = wd[8*i +: 8];
    wait_ready(tag);
    req = 1'b1; we = w; addr = a; size = sz; uns = u; wdata = wd;
    @(posedge clk);
    #1;
    req = 1'b0;
    check({tag, "_rvalid"}, 64'(rvalid), 64'd1);
    check({tag, "_ready"}, 64'(ready), 64'd0);
    check({tag, "_err"}, 64'(err), 64'(mis));
    check({tag, "_rdata"}, rdata, exp_data);
  endtask

  // Start an access, then assert reset while its response is showing
  task automatic rst_in_resp(input bit w, input logic [7:0] a, input logic [63:0] wd);
    if (w) for (int i = 0; i < 8; i++) model_mem[int'(a) + i] = wd[8*i +: 8];
    wait_ready("rr");
    req = 1'b1; we = w; addr = a; size = 2'd3; uns = 1'b0; wdata = wd;
    @(posedge clk);
    #1;
    req = 1'b0;
    check("rr_rvalid_before", 64'(rvalid), 64'd1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rr_rvalid", 64'(rvalid), 64'd0);
    check("rr_err", 64'(err), 64'd0);
    check("rr_rdata", rdata, 64'd0);
    check("rr_ready_in_rst", 64'(ready), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rr_ready_after", 64'(ready), 64'd1);
  endtask

  initial begin
    rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; size = '0; uns = 1'b0; wdata = '0;
    for (int i = 0; i < 256; i++) model_mem[i] = 8'h00;
`ifdef RAM_INIT_PATTERN_EN
    for (int w = 0; w < 32; w++) begin
      logic [63:0] v;
      v = (w == 0) ? 64'd5 : 64'(w + 3);
      for (int b = 0; b < 8; b++) model_mem[w*8 + b] = v[8*b +: 8];
    end
`endif

    repeat (3) @(posedge clk);
    #1;
    check("rst_rvalid", 64'(rvalid), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_rdata", rdata, 64'd0);
    check("rst_ready", 64'(ready), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("idle_ready", 64'(ready), 64'd1);

`ifdef RAM_INIT_PATTERN_EN
    access(1'b0, 8'h00, 2'd3, 1'b0, 64'd0, "init_load0");
`endif

    // Bring contents to the known pattern regardless of build
    for (int w = 0; w < 32; w++)
      access(1'b1, 8'(w * 8), 2'd3, 1'b0, (w == 0) ? 64'd5 : 64'(w + 3), "fill");

    access(1'b0, 8'h00, 2'd3, 1'b0, 64'd0, "load0");
    check("load0_const", rdata, 64'h5);

    access(1'b1, 8'h09, 2'd0, 1'b0, 64'hAB, "st_b09");
    access(1'b0, 8'h08, 2'd3, 1'b0, 64'd0, "ld_d08");
    check("ld_d08_const", rdata, 64'h000000000000AB04);
    access(1'b0, 8'h09, 2'd0, 1'b0, 64'd0, "ld_b09_s");
    check("ld_b09_s_const", rdata, 64'hFFFFFFFFFFFFFFAB);
    access(1'b0, 8'h09, 2'd0, 1'b1, 64'd0, "ld_b09_u");
    check("ld_b09_u_const", rdata, 64'h00000000000000AB);

    access(1'b1, 8'h12, 2'd2, 1'b0, 64'hDEADBEEF, "st_mis");
    check("st_mis_const", 64'(err), 64'd1);
    access(1'b0, 8'h10, 2'd3, 1'b0, 64'd0, "ld_d10");
    check("ld_d10_const", rdata, 64'h5);

    // req held high: one accept every other cycle
    wait_ready("held");
    req = 1'b1; we = 1'b0; addr = 8'h18; size = 2'd3; uns = 1'b0; wdata = '0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1;
      check("held_rvalid", 64'(rvalid), 64'(k % 2 == 0));
      if (k % 2 == 0) check("held_rdata", rdata, model_load(8'h18, 3, 1'b0));
    end
    req = 1'b0;

    rst_in_resp(1'b0, 8'h20, 64'd0);
    rst_in_resp(1'b1, 8'h28, 64'h0123456789ABCDEF);
    access(1'b0, 8'h28, 2'd3, 1'b0, 64'd0, "rr_committed");

    for (int n = 0; n < 300; n++) begin
      logic [63:0] wd;
      wd = {$urandom(), $urandom()};
      access(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 2'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), wd, "rand");
    end

    // Final sweep confirms every byte against the model
    for (int w = 0; w < 32; w++)
      access(1'b0, 8'(w * 8), 2'd3, 1'b0, 64'd0, "sweep");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ram_param.md
RAM_PARAM -- requirements
Module: ram_param

Interface
REQ-001 SHALL have parameter DATA_W, default 64, meaning word width in bits (multiple of 8, 32 or 64).
REQ-002 SHALL have parameter DEPTH, default 32, meaning number of words (power of two).
REQ-003 SHALL have derived localparam ADDR_W = clog2(DEPTH) + clog2(DATA_W/8), meaning byte address width (8 at defaults).
REQ-004 SHALL have port clk, input, 1, meaning the single clock (rising edge).
REQ-005 SHALL have port rst, input, 1, meaning synchronous active-high reset.
REQ-006 SHALL have port req, input, 1, meaning access request.
REQ-007 SHALL have port we, input, 1, meaning 1 = store, 0 = load.
REQ-008 SHALL have port addr, input, ADDR_W, meaning byte address.
REQ-009 SHALL have port size, input, 2, meaning access size: 0 = byte, 1 = half, 2 = word, 3 = double.
REQ-010 SHALL have port uns, input, 1, meaning zero-extend loads when 1 and sign-extend when 0.
REQ-011 SHALL have port wdata, input, DATA_W, meaning store data, right-aligned.
REQ-012 SHALL have port ready, output, 1, meaning the block can accept a request this cycle.
REQ-013 SHALL have port rvalid, output, 1, meaning a response is valid this cycle.
REQ-014 SHALL have port rdata, output, DATA_W, meaning extended load data.
REQ-015 SHALL have port err, output, 1, meaning the current response is an error (qualified by rvalid).

Function
REQ-016 SHALL implement FSM states IDLE and RESP; ready = 1 only in IDLE.
REQ-017 SHALL accept a request when req && ready at a rising edge, then go IDLE->RESP; RESP->IDLE unconditionally on the next edge.
REQ-018 SHALL assert rvalid for exactly the one cycle spent in RESP, so read latency is 1 cycle and throughput is 1 access per 2 cycles.
REQ-019 SHALL ignore req while in RESP, with no state or memory effect.
REQ-020 SHALL form word index = addr[ADDR_W-1:clog2(DATA_W/8)] and byte offset = the low bits.
REQ-021 SHALL flag misalignment when offset mod 2^size != 0.
REQ-022 SHALL treat size bytes > DATA_W/8 (size 3 with DATA_W = 32) as illegal.
REQ-023 SHALL, for a misaligned or illegal request, leave memory unchanged and respond with rvalid = 1, err = 1, rdata = 0.
REQ-024 SHALL, for a legal store, write only the 2^size addressed bytes (byte enables) at the accepting edge; all other bytes of the word are preserved.
REQ-025 SHALL, for a legal store, respond with rvalid = 1, err = 0, rdata = 0.
REQ-026 SHALL, for a legal load, register the word at the accepting edge.
REQ-027 SHALL, for a legal load, present rdata in RESP as the addressed bytes shifted to bit 0 and extended to DATA_W by uns.
REQ-028 SHALL hold rdata = 0 and err = 0 whenever rvalid = 0.
REQ-029 SHALL make a load following a store to the same address return the new data (the store commits before the load is accepted).

Reset
REQ-030 SHALL, while rst = 1, force state IDLE, rvalid = 0, err = 0, rdata = 0; ready SHALL read 0 while rst is asserted.
REQ-031 SHALL discard a pending response when rst is asserted in RESP; a store already committed stays committed.
REQ-032 SHALL NOT alter memory contents on reset.

Configuration
REQ-033 SHALL, with RAM_INIT_PATTERN_EN defined, initialise contents at time zero as mem[0] = 5 and mem[i] = i + 3 for 1 <= i < DEPTH.
REQ-034 SHALL, without RAM_INIT_PATTERN_EN, leave contents uninitialised (X in simulation), with no initial block.

Structure
REQ-035 SHALL define the size encodings (SZ_B, SZ_H, SZ_W, SZ_D) and the FSM state enum in shared package ram_pkg.
REQ-036 SHALL place byte-enable generation, misalignment check, load extraction and extension in combinational sub-module ram_lane_align.
REQ-037 SHALL keep the storage array and FSM in ram_param.

Verification (defaults, RAM_INIT_PATTERN_EN defined)
REQ-038 SHALL cover: reset released, load size = 3 at addr 0x00 -> after 1 cycle rvalid = 1, rdata = 0x5, err = 0, ready = 0 in that cycle.
REQ-039 SHALL cover: store size = 0 at addr 0x09 with wdata 0xAB, then load size = 3 at 0x08 -> rdata = 0x000000000000AB04.
REQ-040 SHALL cover: load size = 0, uns = 0 at 0x09 after the above -> rdata = 0xFFFFFFFFFFFFFFAB; with uns = 1 -> 0x00000000000000AB.
REQ-041 SHALL cover: store size = 2 at 0x12 -> rvalid = 1, err = 1; a following load at 0x10 returns 0x5 unchanged.
REQ-042 SHALL cover: req held high continuously -> accepts every other cycle and the rvalid pulses alternate.
REQ-043 SHALL cover: rst asserted during RESP -> rvalid drops the same edge, then ready = 1 after rst is released.
